// File: rtl/kb_pkg.sv
// Shared constants and state encoding for the keyboard-to-UART bridge.
package kb_pkg;

  localparam int unsigned CODE_W = 8;

  localparam logic [CODE_W-1:0] SC_BREAK  = 8'hF0;
  localparam logic [CODE_W-1:0] SC_EXT    = 8'hE0;
  localparam logic [CODE_W-1:0] SC_LSHIFT = 8'h12;
  localparam logic [CODE_W-1:0] SC_RSHIFT = 8'h59;
  localparam logic [CODE_W-1:0] SC_CAPS   = 8'h58;
  localparam logic [CODE_W-1:0] SC_ENTER  = 8'h5A;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

endpackage

// File: rtl/key2ascii.sv
// Combinational set-2 scan-code to ASCII ROM; letters flagged so caps-lock can be applied outside.
module key2ascii
  import kb_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  input  logic              shift,
  output logic [CODE_W-1:0] ascii_c,
  output logic              is_letter_c
);

  logic [CODE_W-1:0] lo;
  logic [CODE_W-1:0] hi;

  // Unshifted / shifted glyph pair per key; unmapped keys give 00
  always_comb begin
    lo = 8'h00;
    hi = 8'h00;
    case (code)
      8'h1C: {lo, hi} = {8'h61, 8'h41};
      8'h32: {lo, hi} = {8'h62, 8'h42};
      8'h21: {lo, hi} = {8'h63, 8'h43};
      8'h23: {lo, hi} = {8'h64, 8'h44};
      8'h24: {lo, hi} = {8'h65, 8'h45};
      8'h2B: {lo, hi} = {8'h66, 8'h46};
      8'h34: {lo, hi} = {8'h67, 8'h47};
      8'h33: {lo, hi} = {8'h68, 8'h48};
      8'h43: {lo, hi} = {8'h69, 8'h49};
      8'h3B: {lo, hi} = {8'h6A, 8'h4A};
      8'h42: {lo, hi} = {8'h6B, 8'h4B};
      8'h4B: {lo, hi} = {8'h6C, 8'h4C};
      8'h3A: {lo, hi} = {8'h6D, 8'h4D};
      8'h31: {lo, hi} = {8'h6E, 8'h4E};
      8'h44: {lo, hi} = {8'h6F, 8'h4F};
      8'h4D: {lo, hi} = {8'h70, 8'h50};
      8'h15: {lo, hi} = {8'h71, 8'h51};
      8'h2D: {lo, hi} = {8'h72, 8'h52};
      8'h1B: {lo, hi} = {8'h73, 8'h53};
      8'h2C: {lo, hi} = {8'h74, 8'h54};
      8'h3C: {lo, hi} = {8'h75, 8'h55};
      8'h2A: {lo, hi} = {8'h76, 8'h56};
      8'h1D: {lo, hi} = {8'h77, 8'h57};
      8'h22: {lo, hi} = {8'h78, 8'h58};
      8'h35: {lo, hi} = {8'h79, 8'h59};
      8'h1A: {lo, hi} = {8'h7A, 8'h5A};
      8'h45: {lo, hi} = {8'h30, 8'h29};
      8'h16: {lo, hi} = {8'h31, 8'h21};
      8'h1E: {lo, hi} = {8'h32, 8'h40};
      8'h26: {lo, hi} = {8'h33, 8'h23};
      8'h25: {lo, hi} = {8'h34, 8'h24};
      8'h2E: {lo, hi} = {8'h35, 8'h25};
      8'h36: {lo, hi} = {8'h36, 8'h5E};
      8'h3D: {lo, hi} = {8'h37, 8'h26};
      8'h3E: {lo, hi} = {8'h38, 8'h2A};
      8'h46: {lo, hi} = {8'h39, 8'h28};
      8'h0E: {lo, hi} = {8'h60, 8'h7E};
      8'h4E: {lo, hi} = {8'h2D, 8'h5F};
      8'h55: {lo, hi} = {8'h3D, 8'h2B};
      8'h54: {lo, hi} = {8'h5B, 8'h7B};
      8'h5B: {lo, hi} = {8'h5D, 8'h7D};
      8'h5D: {lo, hi} = {8'h5C, 8'h7C};
      8'h4C: {lo, hi} = {8'h3B, 8'h3A};
      8'h52: {lo, hi} = {8'h27, 8'h22};
      8'h41: {lo, hi} = {8'h2C, 8'h3C};
      8'h49: {lo, hi} = {8'h2E, 8'h3E};
      8'h4A: {lo, hi} = {8'h2F, 8'h3F};
      8'h29: {lo, hi} = {8'h20, 8'h20};
      SC_ENTER: {lo, hi} = {8'h0D, 8'h0D};
      8'h66: {lo, hi} = {8'h08, 8'h08};
      default: {lo, hi} = {8'h00, 8'h00};
    endcase
  end

  // Lowercase letters occupy 61..7A, nothing else in the table lands there
  always_comb begin
    is_letter_c = (lo >= 8'h61) && (lo <= 8'h7A);
    ascii_c     = shift ? hi : lo;
  end

endmodule

// File: rtl/kb_uart_bridge.sv
// PS/2 scan-code decoder feeding the UART TX FIFO through a 1-entry holding buffer.
module kb_uart_bridge
  import kb_pkg::*;
#(
  parameter int unsigned DCNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scan_done_tick,
  input  logic [CODE_W-1:0] scan_code,
  input  logic              tx_full,
  output logic              wr_uart,
  output logic [CODE_W-1:0] w_data,
  output logic              caps_led,
  output logic [DCNT_W-1:0] drop_cnt
);

  state_t            state;
  state_t            state_nxt;
  logic              make_c;
  logic              brk_c;
  logic              shift_l;
  logic              shift_r;
  logic              caps;
  logic              caps_held;
  logic              pend_v;
  logic [CODE_W-1:0] pend;
  logic [CODE_W-1:0] rom_ascii_c;
  logic              rom_letter_c;
  logic [CODE_W-1:0] asc_c;
  logic              is_mod_c;
  logic              new_c;

  // Prefix state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Prefix decoding: classify each byte as make, break, or ignored
  always_comb begin
    state_nxt = state;
    make_c    = 1'b0;
    brk_c     = 1'b0;
    if (scan_done_tick) begin
      case (state)
        IDLE: begin
          if (scan_code == SC_EXT)        state_nxt = EXT;
          else if (scan_code == SC_BREAK) state_nxt = BRK;
          else                            make_c    = 1'b1;
        end
        EXT:     state_nxt = (scan_code == SC_BREAK) ? EXT_BRK : IDLE;
        BRK: begin
          brk_c     = 1'b1;
          state_nxt = IDLE;
        end
        EXT_BRK: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  key2ascii u_rom (
    .code        (scan_code),
    .shift       (shift_l | shift_r),
    .ascii_c     (rom_ascii_c),
    .is_letter_c (rom_letter_c)
  );

  // Caps-lock inverts case of letters only; modifier keys never emit
  always_comb begin
    asc_c    = (rom_letter_c && caps) ? (rom_ascii_c ^ 8'h20) : rom_ascii_c;
    is_mod_c = (scan_code == SC_LSHIFT) || (scan_code == SC_RSHIFT) || (scan_code == SC_CAPS);
    new_c    = make_c && !is_mod_c && (asc_c != 8'h00);
  end

  // Shift and caps-lock tracking; caps_held suppresses typematic re-toggles
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_l   <= 1'b0;
      shift_r   <= 1'b0;
      caps      <= 1'b0;
      caps_held <= 1'b0;
    end else if (make_c) begin
      if (scan_code == SC_LSHIFT) shift_l <= 1'b1;
      if (scan_code == SC_RSHIFT) shift_r <= 1'b1;
      if ((scan_code == SC_CAPS) && !caps_held) begin
        caps      <= ~caps;
        caps_held <= 1'b1;
      end
    end else if (brk_c) begin
      if (scan_code == SC_LSHIFT) shift_l   <= 1'b0;
      if (scan_code == SC_RSHIFT) shift_r   <= 1'b0;
      if (scan_code == SC_CAPS)   caps_held <= 1'b0;
    end
  end

  // Output stage: direct write, park in holding buffer, or drop on overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_uart  <= 1'b0;
      w_data   <= '0;
      pend     <= '0;
      pend_v   <= 1'b0;
      drop_cnt <= '0;
    end else begin
      wr_uart <= 1'b0;
      if (pend_v) begin
        if (!tx_full) begin
          wr_uart <= 1'b1;
          w_data  <= pend;
          if (new_c) pend   <= asc_c;
          else       pend_v <= 1'b0;
        end else if (new_c && (drop_cnt != '1)) begin
          drop_cnt <= drop_cnt + DCNT_W'(1);
        end
      end else if (new_c) begin
        if (!tx_full) begin
          wr_uart <= 1'b1;
          w_data  <= asc_c;
        end else begin
          pend   <= asc_c;
          pend_v <= 1'b1;
        end
      end
    end
  end

  assign caps_led = caps;

endmodule
